// File: rtl/polling_substate_ctrl.sv
// LTSSM Polling sub-state sequencer: drives TS1/TS2/compliance transmission, counts
// training sets, and reports a one-cycle done/fail pulse to the link controller.
module polling_substate_ctrl #(
  parameter int unsigned TX_TS1_MIN     = 1024,
  parameter int unsigned RX_TS_MIN      = 8,
  parameter int unsigned TX_TS2_AFTER   = 16,
  parameter int unsigned ACTIVE_TIMEOUT = 24,
  parameter int unsigned CONFIG_TIMEOUT = 48
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic       ei_exit_i,
  output logic       ts_tx_valid_o,
  output logic       ts_tx_is_ts2_o,
  input  logic       ts_tx_ready_i,
  input  logic       rx_ts_valid_i,
  input  logic       rx_ts_is_ts2_i,
  input  logic       rx_ts_compliance_i,
  output logic       compliance_o,
  output logic       en_8b10b_encoder_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       fail_o,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    StIdle       = 3'd0,
    StActive     = 3'd1,
    StConfig     = 3'd2,
    StCompliance = 3'd3,
    StDone       = 3'd4,
    StFail       = 3'd5
  } state_e;

  localparam int unsigned TxMax = (TX_TS1_MIN > TX_TS2_AFTER) ? TX_TS1_MIN : TX_TS2_AFTER;
  localparam int unsigned TmMax = (ACTIVE_TIMEOUT > CONFIG_TIMEOUT) ? ACTIVE_TIMEOUT
                                                                    : CONFIG_TIMEOUT;
  localparam int unsigned TxW = $clog2(TxMax + 1);
  localparam int unsigned RxW = $clog2(RX_TS_MIN + 1);
  localparam int unsigned TmW = $clog2(TmMax + 1);

  localparam logic [TxW-1:0] TxTs1Lim  = TxW'(TX_TS1_MIN);
  localparam logic [TxW-1:0] TxTs2Lim  = TxW'(TX_TS2_AFTER);
  localparam logic [RxW-1:0] RxLim     = RxW'(RX_TS_MIN);
  localparam logic [TmW-1:0] ActTmoLast = TmW'(ACTIVE_TIMEOUT - 1);
  localparam logic [TmW-1:0] CfgTmoLast = TmW'(CONFIG_TIMEOUT - 1);

  state_e         state_q, state_d;
  logic [TxW-1:0] tx_cnt_q, tx_cnt_d;
  logic [RxW-1:0] rx_cnt_q, rx_cnt_d;
  logic [TmW-1:0] timer_q, timer_d;
  logic           ei_seen_q, ei_seen_d;
  logic           got_ts2_q, got_ts2_d;
  logic           ei_prev_q;
  logic           tx_hs, rx_ts1, rx_ts2;

  function automatic logic [TxW-1:0] tx_sat(input logic [TxW-1:0] c, input logic inc,
                                            input logic [TxW-1:0] lim);
    return (inc && (c < lim)) ? c + 1'b1 : c;
  endfunction

  function automatic logic [RxW-1:0] rx_sat(input logic [RxW-1:0] c, input logic inc);
    return (inc && (c < RxLim)) ? c + 1'b1 : c;
  endfunction

  assign tx_hs  = ts_tx_valid_o & ts_tx_ready_i;
  assign rx_ts1 = rx_ts_valid_i & ~rx_ts_is_ts2_i;
  assign rx_ts2 = rx_ts_valid_i & rx_ts_is_ts2_i;

  always_comb begin
    state_d   = state_q;
    tx_cnt_d  = tx_cnt_q;
    rx_cnt_d  = rx_cnt_q;
    timer_d   = timer_q + 1'b1;
    ei_seen_d = ei_seen_q;
    got_ts2_d = got_ts2_q;
    unique case (state_q)
      StIdle: begin
        timer_d = '0;
        if (start_i) state_d = StActive;
      end
      StActive: begin
        tx_cnt_d  = tx_sat(tx_cnt_q, tx_hs, TxTs1Lim);
        rx_cnt_d  = rx_sat(rx_cnt_q, rx_ts_valid_i & ~rx_ts_compliance_i);
        ei_seen_d = ei_seen_q | ei_exit_i;
        if (rx_ts_valid_i && rx_ts_compliance_i) begin
          state_d = StCompliance;
        end else if (tx_cnt_d >= TxTs1Lim && rx_cnt_d >= RxLim) begin
          state_d = StConfig;
        end else if (timer_q == ActTmoLast) begin
          state_d = ei_seen_d ? StCompliance : StFail;
        end
      end
      StConfig: begin
        got_ts2_d = got_ts2_q | rx_ts2;
        rx_cnt_d  = rx_ts1 ? '0 : rx_sat(rx_cnt_q, rx_ts2);
        // The first Rx TS2 beat already enables Tx TS2 counting
        tx_cnt_d  = tx_sat(tx_cnt_q, tx_hs & got_ts2_d, TxTs2Lim);
        if (rx_cnt_d >= RxLim && tx_cnt_d >= TxTs2Lim) begin
          state_d = StDone;
        end else if (timer_q == CfgTmoLast) begin
          state_d = StFail;
        end
      end
      StCompliance: begin
        timer_d = timer_q;
        if (ei_exit_i && !ei_prev_q) state_d = StActive;
      end
      default: begin
        timer_d = '0;
        state_d = StIdle;
      end
    endcase

    if (abort_i) state_d = StIdle;

    if (state_d != state_q) begin
      tx_cnt_d  = '0;
      rx_cnt_d  = '0;
      timer_d   = '0;
      ei_seen_d = 1'b0;
      got_ts2_d = 1'b0;
    end
  end

  // Outputs are registered from the next state so they track state_q exactly.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q            <= StIdle;
      tx_cnt_q           <= '0;
      rx_cnt_q           <= '0;
      timer_q            <= '0;
      ei_seen_q          <= 1'b0;
      got_ts2_q          <= 1'b0;
      ei_prev_q          <= 1'b0;
      ts_tx_valid_o      <= 1'b0;
      ts_tx_is_ts2_o     <= 1'b0;
      compliance_o       <= 1'b0;
      en_8b10b_encoder_o <= 1'b0;
      busy_o             <= 1'b0;
      done_o             <= 1'b0;
      fail_o             <= 1'b0;
      state_o            <= 3'd0;
    end else begin
      state_q            <= state_d;
      tx_cnt_q           <= tx_cnt_d;
      rx_cnt_q           <= rx_cnt_d;
      timer_q            <= timer_d;
      ei_seen_q          <= ei_seen_d;
      got_ts2_q          <= got_ts2_d;
      ei_prev_q          <= ei_exit_i;
      ts_tx_valid_o      <= (state_d == StActive) || (state_d == StConfig);
      ts_tx_is_ts2_o     <= (state_d == StConfig);
      compliance_o       <= (state_d == StCompliance);
      en_8b10b_encoder_o <= (state_d != StIdle);
      busy_o             <= (state_d != StIdle);
      done_o             <= (state_d == StDone);
      fail_o             <= (state_d == StFail);
      state_o            <= state_d;
    end
  end

endmodule

// File: tb/tb_polling_substate_ctrl.sv
// Randomized bench for polling_substate_ctrl against a cycle-level reference model.
module tb_polling_substate_ctrl;

  localparam int TX1 = 16;
  localparam int RXM = 8;
  localparam int TX2 = 16;
  localparam int AT  = 200;
  localparam int CT  = 400;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0, abort = 1'b0, ei_exit = 1'b0, ready = 1'b0;
  logic rxv = 1'b0, rx2 = 1'b0, rxc = 1'b0;
  logic ts_tx_valid_o, ts_tx_is_ts2_o, compliance_o, en_8b10b_encoder_o;
  logic busy_o, done_o, fail_o;
  logic [2:0] state_o;
  logic [9:0] outs;

  int n_cmp = 0, n_err = 0;
  int cyc = 0, n_done = 0, n_fail = 0, done_cyc = 0, fail_cyc = 0;

  // Reference model: state number plus plain integer counts since state entry.
  int m_st, m_tx, m_rx, m_age;
  bit m_ei, m_got, m_prev;

  always #5 clk = ~clk;

  polling_substate_ctrl #(
    .TX_TS1_MIN    (TX1),
    .RX_TS_MIN     (RXM),
    .TX_TS2_AFTER  (TX2),
    .ACTIVE_TIMEOUT(AT),
    .CONFIG_TIMEOUT(CT)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .start_i           (start),
    .abort_i           (abort),
    .ei_exit_i         (ei_exit),
    .ts_tx_valid_o     (ts_tx_valid_o),
    .ts_tx_is_ts2_o    (ts_tx_is_ts2_o),
    .ts_tx_ready_i     (ready),
    .rx_ts_valid_i     (rxv),
    .rx_ts_is_ts2_i    (rx2),
    .rx_ts_compliance_i(rxc),
    .compliance_o      (compliance_o),
    .en_8b10b_encoder_o(en_8b10b_encoder_o),
    .busy_o            (busy_o),
    .done_o            (done_o),
    .fail_o            (fail_o),
    .state_o           (state_o)
  );

  assign outs = {ts_tx_valid_o, ts_tx_is_ts2_o, compliance_o, en_8b10b_encoder_o, busy_o,
                 done_o, fail_o, state_o};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [9:0] exp_outs();
    logic [2:0] s;
    s = 3'(m_st);
    return {(m_st == 1 || m_st == 2), (m_st == 2), (m_st == 3), (m_st != 0), (m_st != 0),
            (m_st == 4), (m_st == 5), s};
  endfunction

  task automatic m_enter(input int s);
    m_st = s; m_tx = 0; m_rx = 0; m_age = 0; m_ei = 0; m_got = 0;
  endtask

  task automatic model_step();
    int tx, rx;
    bit ei, got;
    if (!rst_n) begin
      m_enter(0);
      m_prev = 0;
      return;
    end
    if (abort) m_enter(0);
    else begin
      case (m_st)
        0: if (start) m_enter(1);
        1: begin
          tx = m_tx + int'(ready);
          rx = m_rx + int'(rxv && !rxc);
          ei = m_ei || ei_exit;
          if (rxv && rxc) m_enter(3);
          else if (tx >= TX1 && rx >= RXM) m_enter(2);
          else if (m_age == AT - 1) m_enter(ei ? 3 : 5);
          else begin m_tx = tx; m_rx = rx; m_ei = ei; m_age++; end
        end
        2: begin
          got = m_got || (rxv && rx2);
          rx  = (rxv && !rx2) ? 0 : m_rx + int'(rxv && rx2);
          tx  = m_tx + int'(ready && got);
          if (rx >= RXM && tx >= TX2) m_enter(4);
          else if (m_age == CT - 1) m_enter(5);
          else begin m_tx = tx; m_rx = rx; m_got = got; m_age++; end
        end
        3: if (ei_exit && !m_prev) m_enter(1);
        default: m_enter(0);
      endcase
    end
    m_prev = ei_exit;
  endtask

  task automatic drive(input logic s, input logic a, input logic e, input logic r,
                       input logic v, input logic t2, input logic c);
    start = s; abort = a; ei_exit = e; ready = r; rxv = v; rx2 = t2; rxc = c;
  endtask

  // One clock: compare every output mid-cycle, then advance the model on the edge.
  task automatic tick(input string tag);
    @(negedge clk);
    cyc++;
    check_eq(tag, {22'b0, outs}, {22'b0, exp_outs()});
    if (done_o) begin n_done++; done_cyc = cyc; end
    if (fail_o) begin n_fail++; fail_cyc = cyc; end
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clear_stats();
    n_done = 0; n_fail = 0; done_cyc = 0; fail_cyc = 0;
  endtask

  initial begin
    int base, acc, sent, kcfg, pdone, pabort, pei, pcomp;
    bit cfg_seen;
    m_enter(0);
    m_prev = 0;
    #2 rst_n = 1'b0;
    #1 check_eq("reset_outs", {22'b0, outs}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick("idle");

    // Nominal flow with start_i pulses while busy
    clear_stats();
    drive(1, 0, 0, 1, 0, 0, 0); tick("nom_start");
    sent = 0; kcfg = 0;
    for (int k = 1; k <= 120 && m_st != 0; k++) begin
      start = ($urandom_range(0, 7) == 0);
      if (m_st == 1) begin
        rxv = (sent < RXM) && ($urandom_range(0, 1) == 1 || (10 - k) <= (RXM - sent));
        rx2 = 1'b0;
        if (rxv) sent++;
      end else begin
        rxv = ($urandom_range(0, 1) == 1);
        rx2 = 1'b1;
      end
      tick("nom");
      if (kcfg == 0 && state_o == 3'd2) kcfg = k;
    end
    start = 0; rxv = 0;
    check_eq("nom_cfg_after_16th_ts1", kcfg, TX1);
    check_eq("nom_done_count", n_done, 1);
    check_eq("nom_fail_count", n_fail, 0);
    check_eq("nom_back_idle", {29'b0, state_o}, 32'd0);

    // Active timeout without electrical-idle exit
    clear_stats();
    drive(1, 0, 0, 0, 0, 0, 0); tick("tmo_start");
    base = cyc;
    for (int k = 1; k <= 210; k++) begin
      start = 0; ready = $urandom_range(0, 1);
      tick("tmo");
    end
    check_eq("tmo_fail_count", n_fail, 1);
    check_eq("tmo_fail_cycle", fail_cyc - base, AT + 1);

    // Active timeout with ei seen, then compliance exit and re-entry
    clear_stats();
    drive(1, 0, 0, 1, 0, 0, 0); tick("cmp_start");
    for (int k = 1; k <= 205; k++) begin
      start = 0; ei_exit = (k == 5);
      tick("cmp_tmo");
    end
    check_eq("cmp_state", {29'b0, state_o}, 32'd3);
    check_eq("cmp_compliance_o", {31'b0, compliance_o}, 32'd1);
    ei_exit = 1; tick("cmp_rise");
    check_eq("cmp_exit_to_active", {29'b0, state_o}, 32'd1);
    for (int k = 1; k <= AT + 15; k++) tick("cmp_held");
    check_eq("cmp_held_no_retrigger", {29'b0, state_o}, 32'd3);
    ei_exit = 0; tick("cmp_low");
    ei_exit = 1; tick("cmp_rise2");
    ei_exit = 0;
    kcfg = 0;
    for (int k = 1; k <= 20 && kcfg == 0; k++) begin
      rxv = 1; rx2 = 0; ready = 1;
      tick("cmp_reentry");
      if (state_o == 3'd2) kcfg = k;
    end
    rxv = 0;
    check_eq("cmp_counters_cleared", kcfg, TX1);
    abort = 1; tick("cmp_abort");
    abort = 0;
    check_eq("cmp_abort_idle", {22'b0, outs}, 32'd0);
    check_eq("cmp_no_pulses", n_done + n_fail, 0);

    // Config: TS1 interrupt restarts the consecutive TS2 count
    clear_stats();
    drive(1, 0, 0, 1, 0, 0, 0); tick("int_start");
    for (int k = 1; k <= TX1; k++) begin
      start = 0; rxv = (k <= RXM); rx2 = 0;
      tick("int_act");
    end
    check_eq("int_in_config", {29'b0, state_o}, 32'd2);
    base = cyc;
    for (int j = 1; j <= 20; j++) begin
      rxv = (j <= 14); rx2 = (j != 6);
      tick("int_cfg");
    end
    rxv = 0;
    check_eq("int_done_count", n_done, 1);
    check_eq("int_done_cycle", done_cyc - base, 17);

    // Backpressure: exit Active on exactly the 16th accepted TS1
    clear_stats();
    drive(1, 0, 0, 0, 0, 0, 0); tick("bp_start");
    acc = 0; cfg_seen = 0;
    for (int k = 1; k <= 500 && m_st != 0; k++) begin
      start = 0;
      ready = $urandom_range(0, 1);
      rxv = (m_st == 1) ? (k <= RXM) : ($urandom_range(0, 2) != 0);
      rx2 = (m_st == 1) ? $urandom_range(0, 1) : 1'b1;
      if (m_st == 1 && ready) acc++;
      tick("bp");
      if (!cfg_seen && state_o == 3'd2) begin
        cfg_seen = 1;
        check_eq("bp_accepted_ts1", acc, TX1);
      end
    end
    rxv = 0;
    check_eq("bp_reached_config", {31'b0, cfg_seen}, 32'd1);
    check_eq("bp_done_count", n_done, 1);

    // Abort in Config
    clear_stats();
    drive(1, 0, 0, 1, 1, 0, 0); tick("ab_start");
    start = 0;
    for (int k = 1; k <= TX1 + 3; k++) begin
      rx2 = (m_st == 2);
      tick("ab_run");
    end
    check_eq("ab_in_config", {29'b0, state_o}, 32'd2);
    abort = 1; tick("ab_abort");
    abort = 0; rxv = 0;
    check_eq("ab_idle_outs", {22'b0, outs}, 32'd0);
    tick("ab_idle");
    check_eq("ab_no_pulses", n_done + n_fail, 0);

    // Asynchronous reset mid-Active
    clear_stats();
    drive(1, 0, 0, 1, 1, 0, 0); tick("rs_start");
    start = 0;
    for (int k = 1; k <= 7; k++) tick("rs_run");
    #3 rst_n = 1'b0;
    m_enter(0); m_prev = 0;
    #1 check_eq("rs_async_outs", {22'b0, outs}, 32'd0);
    tick("rs_held");
    rst_n = 1'b1; rxv = 0;
    for (int k = 1; k <= 3; k++) tick("rs_after");
    check_eq("rs_no_pulses", n_done + n_fail, 0);

    // Random traffic including compliance bits, ei toggling and rare aborts
    for (int it = 0; it < 6; it++) begin
      pdone = $urandom_range(1, 3); pabort = $urandom_range(200, 900);
      pei = $urandom_range(3, 40); pcomp = (it < 3) ? 0 : $urandom_range(30, 120);
      for (int k = 0; k < 700; k++) begin
        start = (m_st == 0) ? 1'b1 : ($urandom_range(0, 9) == 0);
        abort = ($urandom_range(0, pabort) == 0);
        if ($urandom_range(0, pei) == 0) ei_exit = ~ei_exit;
        ready = ($urandom_range(0, pdone) != 0);
        rxv = ($urandom_range(0, 1) == 1);
        rx2 = (m_st == 2) ? ($urandom_range(0, 12) != 0) : $urandom_range(0, 1);
        rxc = (pcomp != 0) && ($urandom_range(0, pcomp) == 0);
        tick("rand");
      end
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    tick("end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/polling_substate_ctrl.md
# polling_substate_ctrl

Sequencer for the LTSSM Polling state, sitting below the top-level link controller. It is started when the link controller enters POLLING. It drives the ordered-set transmitter through Polling.Active (TS1), Polling.Configuration (TS2) and Polling.Compliance. It counts transmitted and received training sets and reports a single-cycle done or fail pulse back to the link controller. It also gates the 8b/10b encoder enable for the duration of Polling.

## Interface
Parameters:
- TX_TS1_MIN, 1024: TS1s accepted by the transmitter before Active may exit.
- RX_TS_MIN, 8: consecutive qualifying TSs required to advance (Active and Configuration).
- TX_TS2_AFTER, 16: TS2s accepted after the first qualifying Rx TS2 before Configuration may exit.
- ACTIVE_TIMEOUT, 24: cycle budget in Active (scaled 24 ms).
- CONFIG_TIMEOUT, 48: cycle budget in Configuration (scaled 48 ms).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous, active-low reset.
- start_i  in  1  pulse from the link controller on POLLING entry; ignored unless in IDLE.
- abort_i  in  1  forces return to IDLE; highest priority.
- ei_exit_i  in  1  electrical-idle exit detected on the receiver (level).
- ts_tx_valid_o  out  1  request to transmit one ordered set.
- ts_tx_is_ts2_o  out  1  0 = TS1, 1 = TS2.
- ts_tx_ready_i  in  1  transmitter accepts the set in a cycle with valid & ready.
- rx_ts_valid_i  in  1  one decoded TS received this cycle.
- rx_ts_is_ts2_i  in  1  received set is a TS2.
- rx_ts_compliance_i  in  1  compliance-receive bit in the received set.
- compliance_o  out  1  transmit compliance pattern.
- en_8b10b_encoder_o  out  1  high in every state except IDLE.
- busy_o  out  1  state != IDLE.
- done_o  out  1  one-cycle pulse: proceed to Configuration.
- fail_o  out  1  one-cycle pulse: return to Detect.
- state_o  out  3  IDLE=0, ACTIVE=1, CONFIG=2, COMPLIANCE=3, DONE=4, FAIL=5.

## Operation
- IDLE: start_i goes to ACTIVE. All counters, the timer and the sticky flags are cleared on every state entry.
- ACTIVE:
  - Transmits TS1: valid=1, is_ts2=0. tx_cnt increments on valid & ready.
  - rx_cnt increments on rx_ts_valid_i with compliance=0, TS1 or TS2.
  - Sticky ei_seen sets on ei_exit_i.
  - Rx TS with compliance=1 goes to COMPLIANCE.
  - Otherwise, if tx_cnt ≥ TX_TS1_MIN and rx_cnt ≥ RX_TS_MIN, goes to CONFIG.
  - Otherwise, on timeout: ei_seen=1 goes to COMPLIANCE; ei_seen=0 goes to FAIL.
- COMPLIANCE:
  - ts_tx_valid_o=0, compliance_o=1.
  - A rising edge of ei_exit_i (sampled against its previous-cycle value) goes to ACTIVE. There is no timeout.
- CONFIG:
  - Transmits TS2: valid=1, is_ts2=1.
  - rx_cnt counts consecutive Rx TS2. An Rx TS1 resets rx_cnt to 0.
  - Sticky got_ts2 sets on the first Rx TS2.
  - tx_cnt counts accepted TS2s only while got_ts2 is set, or in the same cycle it sets.
  - rx_cnt ≥ RX_TS_MIN and tx_cnt ≥ TX_TS2_AFTER goes to DONE. Timeout goes to FAIL.
- DONE / FAIL: assert done_o / fail_o for exactly one cycle, then go to IDLE.
- Counter rules:
  - Counters are $clog2(max+1) wide and saturate at their threshold.
  - Exit conditions are evaluated on next-count values, so the qualifying beat's own edge commits the transition.
- Timer:
  - Counts from 0 at state entry. Timeout fires in the cycle where timer == budget-1.
  - If an exit condition and timeout coincide, the exit condition wins.
- abort_i: from any state goes to IDLE at the next edge. No done/fail pulse is produced.
- Outputs are Moore-decoded from the registered state. A pending unaccepted TS on state exit is dropped. is_ts2 never changes while valid & !ready within a state.

## Timing
- Reset values:
  - state IDLE.
  - All outputs 0: ts_tx_valid_o, ts_tx_is_ts2_o, compliance_o, en_8b10b_encoder_o, busy_o, done_o, fail_o, state_o.
  - Counters, timer and flags cleared. Reset mid-operation is immediate.
- Latency:
  - start_i at edge N gives ACTIVE, valid and en_8b10b visible after N.
  - The final qualifying handshake at edge M gives the new state after M.
  - DONE lasts one cycle, so done_o is high during cycle M+1 and IDLE follows at M+2.
- rx_ts_valid_i and the tx handshake may coincide in the same cycle; both counters update.

## Test plan
Bench parameters: TX_TS1_MIN=16, RX_TS_MIN=8, TX_TS2_AFTER=16, ACTIVE_TIMEOUT=200, CONFIG_TIMEOUT=400.
- Nominal: ready=1, 8 Rx TS1 by cycle 10 → CONFIG after the 16th TS1; 8 Rx TS2 then 16 Tx TS2 → one done_o pulse, then IDLE; fail_o never asserted.
- Active timeout with ei_exit_i=0 and no Rx → fail_o at cycle 201 after entry; with ei_exit_i pulsed at cycle 5 → COMPLIANCE and compliance_o=1.
- Compliance exit: in COMPLIANCE, raise ei_exit_i → ACTIVE next cycle with tx/rx counters at 0; held-high ei_exit_i does not re-trigger.
- CONFIG Rx TS1 interrupt: 5 TS2, 1 TS1, 8 TS2 → rx_cnt resets, DONE only after the final 8th TS2 (plus the TX_TS2_AFTER requirement).
- Backpressure: ready toggles 0/1 → tx_cnt counts only valid & ready beats, is_ts2 stable; exit on exactly the 16th accepted TS1.
- abort_i in CONFIG, and rst_ni low mid-ACTIVE → IDLE, all outputs 0, no done/fail pulse; start_i while busy ignored.
